hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the 5-stage 16-bit pipeline; successor to the fixed stall/flush/forward stub. It tracks in-flight register writers in a shift-register scoreboard (one slot per stage after decode), detects read-after-write and load-use hazards for the instruction in decode, and drives stall, flush and registered forwarding selects for the EX-stage operand muxes. It also counts stall cycles for performance analysis.

## Interface
Parameters:
- AW, 5, register address width; address 0 is hardwired zero and never hazards
- DEPTH, 3, scoreboard slots after decode (slot 0 = EX, slot DEPTH-1 = WB); legal range 3..8
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_ra, id_rb  in  AW  decode source register addresses
- id_use_a, id_use_b  in  1  source actually read
- id_wa  in  AW  decode destination address
- id_we  in  1  decode instruction writes a register
- id_is_load  in  1  decode instruction is a data-memory load
- ex_redirect  in  1  branch/jump resolved taken in EX this cycle
- stall  out  1  hold PC and stage-1 pipeline register
- flush  out  1  clear stage-1 and stage-2 pipeline registers
- fwd_a, fwd_b  out  2  EX operand select: 0 regfile, 1 MEM-stage value, 2 WB-stage value
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1

## Operation
- Slot k = {valid, wa, we, load}. Each rising edge: slot k+1 <= slot k for k < DEPTH-1; slot DEPTH-1's contents retire.
- Slot 0 loads the decode instruction when id_valid & !stall & !ex_redirect; otherwise loads a bubble (valid=0).
- Match(k, r) = slot k valid & we & wa==r & r!=0.
- Sources considered only when id_valid and the matching id_use_* is 1.
- Regfile is write-first; slot DEPTH-1 (WB) never causes a hazard.
- Load-use: Match(0, src) with slot 0 load -> stall.
- With forwarding (see Configuration), per source, youngest match wins: Match(0) -> select 1; else Match(1) -> select 2; else Match(k) for 2 <= k <= DEPTH-2 -> stall (no forwarding path); else select 0.
- stall = id_valid & any stall condition & !ex_redirect.
- flush = ex_redirect (redirect has priority over stall; stall forced 0).
- fwd_a/fwd_b registered: computed in decode, captured at the edge the instruction enters EX; captured as 0 when a bubble enters slot 0.
- stall_cycles increments on every edge with stall=1; saturates at all-ones; never wraps.
- Reset mid-operation: all slots invalid, counters and registered outputs cleared immediately (asynchronous).

## Timing
- Reset values: stall 0, flush 0, fwd_a 0, fwd_b 0, stall_cycles 0, all slots invalid.
- stall and flush are combinational from inputs and slot state, valid within the same cycle.
- fwd_a/fwd_b: one-cycle latency, stable for the full EX cycle of the consuming instruction.
- Load-use costs exactly 1 stall cycle with forwarding; the instruction then proceeds with select 2.
- Redirect: one flush cycle; slot 0 gets a bubble on that edge; wrong-path decode instruction never enters the scoreboard.
- Simultaneous stall condition and ex_redirect: flush=1, stall=0, counter not incremented.

## Configuration
- HAZARD_FORWARDING_EN defined: forwarding as in Operation; only load-use and slots 2..DEPTH-2 stall.
- Undefined: fwd_a/fwd_b tied to 0; any Match(k) for 0 <= k <= DEPTH-2 stalls until the writer reaches WB.

## Test plan
- Reset: assert rst mid-stream with slots full -> all outputs 0 within the same cycle, slots invalid after release.
- ALU RAW: write r3, next instruction reads r3 as a (forwarding on) -> stall 0, fwd_a=1 in EX; two instructions later -> fwd_a=2.
- Load-use: load r4, next reads r4 as b -> stall=1 for one cycle, stall_cycles=1, then fwd_b=2 in EX.
- r0 and unused sources: writer to r0, or id_use_a=0 with matching address -> stall 0, fwd 0.
- Redirect with pending load-use stall -> flush=1, stall=0, stall_cycles unchanged, slot 0 bubble.
- Forwarding off, DEPTH=3: write r5 then read r5 -> stall 2 cycles, stall_cycles=2, fwd 0; counter at all-ones plus stall -> stays all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard interface: decode instruction fields and redirect in,
// stall/flush/forward controls and the stall-cycle counter out.
interface hazard_scoreboard_if #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [AW-1:0]    id_ra;
   logic [AW-1:0]    id_rb;
   logic             id_use_a;
   logic             id_use_b;
   logic [AW-1:0]    id_wa;
   logic             id_we;
   logic             id_is_load;
   logic             ex_redirect;
   logic             stall;
   logic             flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_valid, id_ra, id_rb, id_use_a, id_use_b,
             id_wa, id_we, id_is_load, ex_redirect,
      input  stall, flush, fwd_a, fwd_b, stall_cycles
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_use_a, id_use_b,
             id_wa, id_we, id_is_load, ex_redirect,
      output stall, flush, fwd_a, fwd_b, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Tracks in-flight register writers in a shift-register scoreboard, raises
// stall for load-use and unforwardable RAW hazards, flush on EX redirect,
// and registers the EX operand forwarding selects.
// Optional feature macro: HAZARD_FORWARDING_EN (defined = MEM/WB forwarding
// enabled; undefined = every in-flight writer before WB stalls decode).
// The WB slot is not stored: the regfile is write-first, so a writer in WB
// can never cause a hazard and only slots 0..DEPTH-2 need tracking.
module hazard_scoreboard #(
   parameter int AW    = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave bus
);

   localparam int TRACK = DEPTH - 1;

   logic [TRACK-1:0] slot_valid_q, slot_valid_d;
   logic [TRACK-1:0] slot_we_q, slot_we_d;
   logic [TRACK-1:0] slot_load_q, slot_load_d;
   logic [AW-1:0]    slot_wa_q [TRACK];
   logic [AW-1:0]    slot_wa_d [TRACK];

   logic [TRACK-1:0] match_a, match_b;
   logic             stall_a, stall_b;
   logic             stall_int;
   logic             enter;

   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

`ifdef HAZARD_FORWARDING_EN
   logic [1:0] sel_a, sel_b;
   logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
`endif

   // Compare each used, non-zero decode source against every tracked writer
   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int k = 0; k < TRACK; k++) begin
         match_a[k] = bus.id_valid & bus.id_use_a & slot_valid_q[k] & slot_we_q[k]
                      & (slot_wa_q[k] == bus.id_ra) & (bus.id_ra != '0);
         match_b[k] = bus.id_valid & bus.id_use_b & slot_valid_q[k] & slot_we_q[k]
                      & (slot_wa_q[k] == bus.id_rb) & (bus.id_rb != '0);
      end
   end

   // Resolve per-source hazards; youngest matching writer decides the outcome
   always_comb begin
      stall_a = match_a[0] & slot_load_q[0];
      stall_b = match_b[0] & slot_load_q[0];
`ifdef HAZARD_FORWARDING_EN
      sel_a = 2'd0;
      sel_b = 2'd0;
      if (match_a[0]) begin
         sel_a = 2'd1;
      end else if (match_a[1]) begin
         sel_a = 2'd2;
      end else begin
         stall_a = |(match_a >> 2);
      end
      if (match_b[0]) begin
         sel_b = 2'd1;
      end else if (match_b[1]) begin
         sel_b = 2'd2;
      end else begin
         stall_b = |(match_b >> 2);
      end
`else
      stall_a = stall_a | (|match_a);
      stall_b = stall_b | (|match_b);
`endif
      stall_int = bus.id_valid & (stall_a | stall_b) & ~bus.ex_redirect;
      enter     = bus.id_valid & ~stall_int & ~bus.ex_redirect;
   end

   // Advance the scoreboard: older slots shift, slot 0 takes decode or a bubble
   always_comb begin
      slot_valid_d    = slot_valid_q << 1;
      slot_we_d       = slot_we_q << 1;
      slot_load_d     = slot_load_q << 1;
      slot_valid_d[0] = enter;
      slot_we_d[0]    = enter & bus.id_we;
      slot_load_d[0]  = enter & bus.id_is_load;
      slot_wa_d[0]    = enter ? bus.id_wa : '0;
      for (int k = 1; k < TRACK; k++) begin
         slot_wa_d[k] = slot_wa_q[k-1];
      end
   end

   // Saturating count of stalled cycles
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_int && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   // Scoreboard and counter state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid_q   <= '0;
         slot_we_q      <= '0;
         slot_load_q    <= '0;
         slot_wa_q      <= '{default: '0};
         stall_cycles_q <= '0;
      end else begin
         slot_valid_q   <= slot_valid_d;
         slot_we_q      <= slot_we_d;
         slot_load_q    <= slot_load_d;
         slot_wa_q      <= slot_wa_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

`ifdef HAZARD_FORWARDING_EN
   // Selects follow the instruction into EX; a bubble entering EX reads the regfile
   always_comb begin
      fwd_a_d = enter ? sel_a : 2'd0;
      fwd_b_d = enter ? sel_b : 2'd0;
   end

   // Registered forwarding selects, stable for the whole EX cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a_q <= 2'd0;
         fwd_b_q <= 2'd0;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign bus.fwd_a = fwd_a_q;
   assign bus.fwd_b = fwd_b_q;
`else
   assign bus.fwd_a = 2'd0;
   assign bus.fwd_b = 2'd0;
`endif

   assign bus.stall        = stall_int;
   assign bus.flush        = bus.ex_redirect;
   assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (DEPTH=3, 4-bit stall counter).
// Table rows describe one decode cycle: inputs held in decode plus the
// outputs expected during that cycle. Honours HAZARD_FORWARDING_EN.
module tb_hazard_scoreboard;

   localparam int AW    = 5;
   localparam int DEPTH = 3;
   localparam int CNT_W = 4;
`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      logic       v;
      logic [4:0] ra;
      logic       ua;
      logic [4:0] rb;
      logic       ub;
      logic [4:0] wa;
      logic       we;
      logic       ld;
      logic       rd;
      logic       eStall;
      logic       eFlush;
      logic [1:0] eFa;
      logic [1:0] eFb;
      logic [3:0] eCnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   vec_t tbl[$];

   hazard_scoreboard_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

   hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Absolute time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] time limit reached");
   end

   function automatic vec_t mk(int v, int ra, int ua, int rb, int ub, int wa, int we,
                               int ld, int rd, int es, int ef, int efa, int efb, int ecnt);
      vec_t r;
      r.v = 1'(v);   r.ra = 5'(ra); r.ua = 1'(ua); r.rb = 5'(rb); r.ub = 1'(ub);
      r.wa = 5'(wa); r.we = 1'(we); r.ld = 1'(ld); r.rd = 1'(rd);
      r.eStall = 1'(es); r.eFlush = 1'(ef); r.eFa = 2'(efa); r.eFb = 2'(efb);
      r.eCnt = 4'(ecnt);
      return r;
   endfunction

   function automatic int sat(int n);
      return (n > 15) ? 15 : n;
   endfunction

   task automatic applyStimulus(input vec_t r);
      bus.id_valid    = r.v;
      bus.id_ra       = r.ra;
      bus.id_use_a    = r.ua;
      bus.id_rb       = r.rb;
      bus.id_use_b    = r.ub;
      bus.id_wa       = r.wa;
      bus.id_we       = r.we;
      bus.id_is_load  = r.ld;
      bus.ex_redirect = r.rd;
   endtask

   task automatic checkVal(input string name, input int idx, input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s row %0d: got %0d, expected %0d", name, idx, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input int idx, input vec_t r);
      checkVal({tag, ".stall"}, idx, 32'(bus.stall), 32'(r.eStall));
      checkVal({tag, ".flush"}, idx, 32'(bus.flush), 32'(r.eFlush));
      checkVal({tag, ".fwd_a"}, idx, 32'(bus.fwd_a), 32'(r.eFa));
      checkVal({tag, ".fwd_b"}, idx, 32'(bus.fwd_b), 32'(r.eFb));
      checkVal({tag, ".stall_cycles"}, idx, 32'(bus.stall_cycles), 32'(r.eCnt));
   endtask

   task automatic runTable(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         applyStimulus(tbl[i]);
         @(negedge clk);
         checkOutput(tag, i, tbl[i]);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int   n;
      int   fbNext;
      int   stallLen;
      vec_t idle;

      idle = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
      rst  = 1'b0;
      applyStimulus(idle);
      #2;
      doReset();

      // Reset values, r0, unused sources, redirect over load-use, wrong path
      tbl.delete();
      //                 v ra ua rb ub wa we ld rd  st fl fa fb cnt
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 7, 0, 7, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 4, 1, 2, 1, 0, 1,  0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      runTable("basic");

      doReset();
      tbl.delete();
`ifdef HAZARD_FORWARDING_EN
      // ALU RAW forwarding, load-use single stall, both sources, youngest wins
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3, 1, 0, 0, 6, 1, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3, 1, 3, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 0, 0, 2, 1));
      tbl.push_back(mk(1, 9, 1, 9, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0,10, 1, 0, 0,  0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0,10, 1, 0, 0,  0, 0, 0, 0, 1));
      tbl.push_back(mk(1,10, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1));
      runTable("fwd_on");
`else
      // No forwarding: RAW holds decode until the writer reaches WB
      tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1));
      tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2));
      tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0,  0, 0, 0, 0, 2));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2));
      tbl.push_back(mk(1, 0, 0, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2));
      tbl.push_back(mk(1, 0, 0, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 3));
      tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0,  1, 0, 0, 0, 3));
      tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0,  1, 0, 0, 0, 4));
      tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0, 5));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 5));
      runTable("fwd_off");
`endif

      // Repeated load-use pairs drive the 4-bit counter into saturation
      doReset();
      tbl.delete();
      n        = 0;
      fbNext   = 0;
      stallLen = FWD ? 1 : 2;
      for (int it = 0; it < 18; it++) begin
         tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, fbNext, sat(n)));
         for (int s = 0; s < stallLen; s++) begin
            tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, sat(n)));
            n++;
         end
         tbl.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, sat(n)));
         fbNext = FWD ? 2 : 0;
      end
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fbNext, sat(n)));
      runTable("saturate");

      // Asynchronous reset in the middle of a cycle with a writer in flight
      @(posedge clk);
      #1;
      applyStimulus(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      applyStimulus(mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      checkVal("pre_rst.stall", 0, 32'(bus.stall), FWD ? 32'd0 : 32'd1);
      checkVal("pre_rst.stall_cycles", 0, 32'(bus.stall_cycles), 32'd15);
      #1;
      rst = 1'b1;
      #1;
      checkVal("in_rst.stall", 0, 32'(bus.stall), 32'd0);
      checkVal("in_rst.flush", 0, 32'(bus.flush), 32'd0);
      checkVal("in_rst.fwd_a", 0, 32'(bus.fwd_a), 32'd0);
      checkVal("in_rst.fwd_b", 0, 32'(bus.fwd_b), 32'd0);
      checkVal("in_rst.stall_cycles", 0, 32'(bus.stall_cycles), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkVal("post_rst.stall", 0, 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(idle);
      @(negedge clk);
      checkVal("post_rst.fwd_a", 1, 32'(bus.fwd_a), 32'd0);
      checkVal("post_rst.fwd_b", 1, 32'(bus.fwd_b), 32'd0);
      checkVal("post_rst.stall_cycles", 1, 32'(bus.stall_cycles), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
